busca_sar: RTL and testbench
============================

Name: busca_sar

Overview:
- Sequential binary-search unit that acts as the initiator of a magnitude comparator.
- Drives a candidate value `palpite` onto the comparator's X input; an unknown value sits on the comparator's Y input.
- Each cycle it consumes the comparator flags `ma`/`me`/`ig` and narrows the search range until equality is found.
- Used for successive-approximation lookups, e.g. finding a threshold or a stored key, against the existing 4-bit comparator.

Parameters:
- WIDTH, 4, width of the searched value; legal range 2..8.
- PW, 4, width of the step counter; must satisfy 2^PW > WIDTH+1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a search; sampled only in IDLE.
- ma  in  1  comparator flag: palpite > unknown.
- me  in  1  comparator flag: palpite < unknown.
- ig  in  1  comparator flag: palpite == unknown.
- palpite  out  WIDTH  current candidate, registered; feeds comparator X.
- busy  out  1  high while in BUSCA.
- done  out  1  one-cycle pulse when a search ends (success or error).
- resultado  out  WIDTH  value found; held until the next done.
- passos  out  PW  number of comparisons consumed by the last/current search.
- erro  out  1  last search ended in error; held until next start.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - state=IDLE.
  - palpite=0, busy=0, done=0, resultado=0, passos=0, erro=0.
  - lo=0, hi=2^WIDTH-1.
  - rst has priority over every other input, including mid-search; the search is abandoned with no done pulse.
- Internal registers: lo, hi (WIDTH bits each). Midpoint is computed as (lo+hi)>>1 in WIDTH+1 bits, with no overflow.
- IDLE:
  - done=0 except for the pulse cycle.
  - On start=1: lo=0, hi=2^WIDTH-1, palpite=(2^WIDTH-1)>>1, passos=0, erro=0, busy=1, go to BUSCA.
- BUSCA: the comparator is combinational from the registered palpite; flags are sampled on the edge after palpite is updated, one comparison per cycle. Every cycle passos increments by 1.
  - ig=1 (ma=me=0): resultado=palpite, done=1 for one cycle, busy=0, go to IDLE.
  - me=1 (ma=ig=0): lo=palpite+1; palpite=(palpite+1+hi)>>1.
  - ma=1 (me=ig=0): hi=palpite-1; palpite=(lo+palpite-1)>>1.
  - Flags not exactly one-hot (000, or two or more set): erro=1, done=1, busy=0, go to IDLE; resultado is unchanged.
  - Range collapse (me with palpite=hi, or ma with palpite=lo; this also covers palpite=2^WIDTH-1 with me, and palpite=0 with ma): erro=1, done=1, go to IDLE.
- start while in BUSCA is ignored.
- start in the same cycle as the done pulse is ignored; a new start is accepted from the next IDLE cycle.
- Worst-case latency: WIDTH+1 comparisons, so done arrives at most WIDTH+2 cycles after the start edge.
- passos saturates at 2^PW-1 (unreachable with legal parameters).
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (WIDTH=4; a bench model comparator drives ma/me/ig from palpite vs secret):
- secret=7, pulse start → first palpite=7, ig at the next edge; done pulses one cycle later, resultado=7, passos=1, erro=0.
- secret=0 → palpite sequence 7,3,1,0; done with resultado=0, passos=4.
- secret=15 → palpite sequence 7,11,13,14,15; resultado=15, passos=5 (worst case).
- secret=10 → palpite sequence 7,11,9,10; resultado=10, passos=4. A start pulse while busy=1 has no effect on the sequence.
- Force ma=me=1 on the second comparison → erro=1, done pulse, resultado keeps its previous value, busy=0.
- Assert rst at passos=2 during a search for secret=15 → next cycle all outputs 0, state IDLE, no done. A fresh start then completes normally with passos=5.

Source files
------------

// File: rtl/busca_sar.sv
// busca_sar: successive-approximation search that drives a magnitude comparator.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset, wins over every other input
//   start     in   begin a search (honoured only in idle, not in the done cycle)
//   ma        in   comparator flag: palpite > unknown
//   me        in   comparator flag: palpite < unknown
//   ig        in   comparator flag: palpite == unknown
//   palpite   out  registered candidate driven onto the comparator X input
//   busy      out  high while a search is running
//   done      out  one-cycle pulse when a search ends, on success or on error
//   resultado out  value found, held until the next successful search
//   passos    out  comparisons consumed by the last/current search (saturating)
//   erro      out  last search ended in error, held until the next start
//
// Legal parameters: WIDTH in 2..8, 2**PW > WIDTH+1.
module busca_sar #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned PW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ma,
   input  logic             me,
   input  logic             ig,
   output logic [WIDTH-1:0] palpite,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] resultado,
   output logic [PW-1:0]    passos,
   output logic             erro
);

   typedef enum logic {StIdle, StBusca} state_t;

   localparam logic [WIDTH-1:0] MaxVal = '1;
   localparam logic [WIDTH:0]   OneW   = 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] palpite_q, palpite_d;
   logic [WIDTH-1:0] resultado_q, resultado_d;
   logic [PW-1:0]    passos_q, passos_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             erro_q, erro_d;

   logic [2:0]       flags;
   logic [WIDTH:0]   sum_me;
   logic [WIDTH:0]   sum_ma;
   logic [PW-1:0]    passos_inc;

   assign flags = {ma, me, ig};

   // Midpoints of the narrowed range, one bit wider so the sum cannot overflow.
   // sum_ma wraps only when palpite == lo, which is a range collapse and is discarded.
   assign sum_me = {1'b0, palpite_q} + OneW + {1'b0, hi_q};
   assign sum_ma = {1'b0, lo_q} + {1'b0, palpite_q} - OneW;

   assign passos_inc = (passos_q == '1) ? passos_q : passos_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         lo_q        <= '0;
         hi_q        <= MaxVal;
         palpite_q   <= '0;
         resultado_q <= '0;
         passos_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         erro_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         palpite_q   <= palpite_d;
         resultado_q <= resultado_d;
         passos_q    <= passos_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         erro_q      <= erro_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      palpite_d   = palpite_q;
      resultado_d = resultado_q;
      passos_d    = passos_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      erro_d      = erro_q;

      unique case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            // done_q marks the pulse cycle; a start arriving then is dropped
            if (start && !done_q) begin
               lo_d      = '0;
               hi_d      = MaxVal;
               palpite_d = MaxVal >> 1;
               passos_d  = '0;
               erro_d    = 1'b0;
               busy_d    = 1'b1;
               state_d   = StBusca;
            end
         end

         StBusca: begin
            passos_d = passos_inc;
            case (flags)
               3'b001: begin
                  resultado_d = palpite_q;
                  done_d      = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = StIdle;
               end
               3'b010: begin
                  if (palpite_q == hi_q) begin
                     erro_d  = 1'b1;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = StIdle;
                  end else begin
                     lo_d      = palpite_q + 1'b1;
                     palpite_d = sum_me[WIDTH:1];
                  end
               end
               3'b100: begin
                  if (palpite_q == lo_q) begin
                     erro_d  = 1'b1;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = StIdle;
                  end else begin
                     hi_d      = palpite_q - 1'b1;
                     palpite_d = sum_ma[WIDTH:1];
                  end
               end
               default: begin
                  // Inconsistent comparator flags
                  erro_d  = 1'b1;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end
            endcase
         end

         default: state_d = StIdle;
      endcase
   end

   assign palpite   = palpite_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign resultado = resultado_q;
   assign passos    = passos_q;
   assign erro      = erro_q;

endmodule

// File: tb/tb_busca_sar.sv
// Self-checking bench for busca_sar (WIDTH=4). A behavioural comparator drives
// ma/me/ig from palpite vs. a secret; an override path injects bad flags.
module tb_busca_sar;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned PW    = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             ma, me, ig;
   logic [WIDTH-1:0] palpite;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] resultado;
   logic [PW-1:0]    passos;
   logic             erro;

   logic [WIDTH-1:0] secret;
   logic             ovr;
   logic [2:0]       ovr_flags;

   int checks = 0;
   int errors = 0;
   int last_res = 0;

   always #5 clk = ~clk;

   busca_sar #(.WIDTH(WIDTH), .PW(PW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ma        (ma),
      .me        (me),
      .ig        (ig),
      .palpite   (palpite),
      .busy      (busy),
      .done      (done),
      .resultado (resultado),
      .passos    (passos),
      .erro      (erro)
   );

   always_comb begin
      ma = 1'b0;
      me = 1'b0;
      ig = 1'b0;
      if (ovr) begin
         {ma, me, ig} = ovr_flags;
      end else begin
         ma = (palpite > secret);
         me = (palpite < secret);
         ig = (palpite == secret);
      end
   end

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      ovr   = 1'b0;
      ovr_flags = 3'b000;
      secret = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({palpite, busy, done, resultado, passos, erro} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got pal=%0d busy=%0b done=%0b res=%0d passos=%0d erro=%0b, want all 0",
                  palpite, busy, done, resultado, passos, erro);
      end
      last_res = 0;
   endtask

   // Runs one search; the expected probe sequence comes from a plain integer binary search.
   task automatic run_search(input int sec, input bit mid_start, input bit start_on_done);
      int exp_q[$];
      int got_q[$];
      int lo, hi, p;
      bit got_done;
      bit same;
      lo = 0;
      hi = (1 << WIDTH) - 1;
      forever begin
         p = (lo + hi) / 2;
         exp_q.push_back(p);
         if (p == sec) break;
         if (p < sec) lo = p + 1;
         else hi = p - 1;
      end

      secret = WIDTH'(sec);
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got_done = 1'b0;
      for (int c = 0; c < 20 && !got_done; c++) begin
         if (done) begin
            got_done = 1'b1;
         end else begin
            if (busy) got_q.push_back(int'(palpite));
            start = (mid_start && c == 1);
            @(negedge clk);
            start = 1'b0;
         end
      end

      checks++;
      if (!got_done) begin
         errors++;
         $display("FAIL search_timeout: secret=%0d got no done within 20 cycles, want done", sec);
      end
      same = (got_q.size() == exp_q.size());
      if (same) foreach (exp_q[i]) if (got_q[i] != exp_q[i]) same = 1'b0;
      checks++;
      if (!same) begin
         errors++;
         $display("FAIL probe_seq: secret=%0d got %p, want %p", sec, got_q, exp_q);
      end
      checks++;
      if (int'(resultado) !== sec) begin
         errors++;
         $display("FAIL resultado: secret=%0d got %0d, want %0d", sec, resultado, sec);
      end
      checks++;
      if (int'(passos) !== exp_q.size()) begin
         errors++;
         $display("FAIL passos: secret=%0d got %0d, want %0d", sec, passos, exp_q.size());
      end
      checks++;
      if ({erro, busy} !== 2'b00) begin
         errors++;
         $display("FAIL status_done: secret=%0d got erro=%0b busy=%0b, want 0 0", sec, erro, busy);
      end
      if (got_done) last_res = sec;

      start = start_on_done;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL pulse_end: secret=%0d got done=%0b busy=%0b, want 0 0", sec, done, busy);
      end
      if (start_on_done) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_on_done: got busy=%0b, want 0", busy);
         end
      end
   endtask

   task automatic test_directed();
      run_search(7, 1'b0, 1'b0);
      run_search(0, 1'b0, 1'b0);
      run_search(15, 1'b0, 1'b0);
      run_search(10, 1'b1, 1'b0);
   endtask

   task automatic test_start_on_done();
      run_search(5, 1'b0, 1'b1);
      run_search(12, 1'b0, 1'b0);
   endtask

   // Overrides the flags from comparison number from_cmp onward.
   task automatic test_forced(input logic [2:0] f, input int from_cmp, input int sec,
                              input int exp_passos);
      bit got_done;
      int c;
      secret    = WIDTH'(sec);
      ovr_flags = f;
      start     = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      got_done = 1'b0;
      c = 1;
      while (c < 20 && !got_done) begin
         if (done) begin
            got_done = 1'b1;
         end else begin
            if (c >= from_cmp) ovr = 1'b1;
            @(negedge clk);
            c++;
         end
      end
      ovr = 1'b0;
      checks++;
      if (!got_done) begin
         errors++;
         $display("FAIL forced_timeout: flags=%b got no done, want done", f);
      end
      checks++;
      if ({erro, busy} !== 2'b10) begin
         errors++;
         $display("FAIL forced_status: flags=%b got erro=%0b busy=%0b, want 1 0", f, erro, busy);
      end
      checks++;
      if (int'(resultado) !== last_res) begin
         errors++;
         $display("FAIL forced_resultado: flags=%b got %0d, want %0d", f, resultado, last_res);
      end
      checks++;
      if (int'(passos) !== exp_passos) begin
         errors++;
         $display("FAIL forced_passos: flags=%b got %0d, want %0d", f, passos, exp_passos);
      end
      @(negedge clk);
      checks++;
      if ({done, erro} !== 2'b01) begin
         errors++;
         $display("FAIL forced_hold: got done=%0b erro=%0b, want 0 1", done, erro);
      end
   endtask

   task automatic test_errors();
      test_forced(3'b110, 2, 15, 2);   // ma and me together
      test_forced(3'b000, 1, 9, 1);    // no flag
      test_forced(3'b111, 3, 4, 3);    // all flags
      test_forced(3'b010, 1, 0, 5);    // me forever: collapses at 15
      test_forced(3'b100, 1, 0, 4);    // ma forever: collapses at 0
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_search(int'($urandom_range(0, (1 << WIDTH) - 1)), bit'($urandom_range(0, 1)),
                    1'b0);
      end
   endtask

   task automatic test_reset_mid_search();
      bit saw_done;
      secret = 4'd15;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (passos !== 4'd2) begin
         errors++;
         $display("FAIL mid_passos: got %0d, want 2", passos);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({palpite, busy, done, resultado, passos, erro} !== '0) begin
         errors++;
         $display("FAIL mid_reset: got pal=%0d busy=%0b done=%0b res=%0d passos=%0d erro=%0b, want all 0",
                  palpite, busy, done, resultado, passos, erro);
      end
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle: got activity after reset, want none");
      end
      last_res = 0;
      run_search(15, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_on_done();
      test_errors();
      test_random();
      test_reset_mid_search();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
